lfsr_run_ctrl: RTL and testbench
================================

// Module: lfsr_run_ctrl
// PURPOSE
//  Sequencer for the LFSR datapath. On a start request it clears the LFSR, loads its seed,
//  then enables it for exactly run_len cycles. At the end it captures the final LFSR state
//  as a signature and signals done. Sits between top-level control and the LFSR, driving its
//  lfsr_rst / lfsr_load / lfsr_en controls.
// PARAMETERS
//  WIDTH  16  LFSR state / signature width
//  CNT_W  16  run-length counter width
// PORTS
//  clk        in   1      system clock, rising edge
//  reset      in   1      asynchronous, active-low reset; 0 clears all state immediately
//  start      in   1      run request; sampled only in IDLE
//  stop       in   1      abort; sampled in any non-IDLE state
//  run_len    in   CNT_W  number of LFSR enable cycles; latched in LOAD
//  lfsr_q     in   WIDTH  current LFSR state from datapath
//  lfsr_rst   out  1      synchronous clear to LFSR
//  lfsr_load  out  1      seed-load strobe to LFSR
//  lfsr_en    out  1      LFSR step enable
//  busy       out  1      high from CLR through DONE
//  done       out  1      one-cycle completion pulse
//  count      out  CNT_W  enable cycles issued in current/last run
//  sig        out  WIDTH  captured signature
// BEHAVIOUR
//  - Reset (reset=0): state=IDLE; all outputs 0; count=0; sig=0; latched run_len=0.
//  - FSM states: IDLE, CLR, LOAD, RUN, DONE. Outputs are decoded from registered state and
//    are glitch-free.
//  - IDLE: all strobes 0. If start=1 -> CLR.
//  - CLR (1 cycle): lfsr_rst=1, count<=0 -> LOAD.
//  - LOAD (1 cycle): lfsr_load=1, len_q<=run_len -> RUN if run_len!=0, else DONE.
//  - RUN: lfsr_en=1; count increments each cycle; at edge with count==len_q-1 -> DONE.
//    Gives exactly len_q enable cycles, final count=len_q. count never wraps.
//  - DONE (1 cycle): sig<=lfsr_q (value after final step) at the closing edge -> IDLE.
//  - done=1 for exactly the first cycle back in IDLE; sig already holds the new value then.
//  - Latency: start sampled at edge t -> CLR t+1, LOAD t+2, RUN t+3..t+2+N, DONE t+3+N,
//    done pulse t+4+N.
//  - stop=1 in CLR/LOAD/RUN/DONE -> IDLE at next edge; no done pulse; sig unchanged;
//    count holds its value. stop has priority over the RUN->DONE transition.
//  - start while busy is ignored. If start is held high, a new run begins from the
//    done-pulse cycle (that cycle is IDLE).
//  - stop in IDLE has no effect. start and stop both high in IDLE -> start wins.
//  - reset asserted mid-run: immediate return to IDLE with reset values; no done pulse.
// CONFIGURATION
//  LFSR_SIG_CHECK_EN defined:
//   - adds ports exp_sig (in, WIDTH), pass (out, 1), fail (out, 1).
//   - exp_sig latched in LOAD.
//   - at the DONE closing edge: pass<=(lfsr_q==exp_q), fail<=!(lfsr_q==exp_q).
//   - pass/fail hold until cleared in the next CLR; reset value 0. Abort leaves both at 0.
//  LFSR_SIG_CHECK_EN undefined: ports absent, no comparator or exp_sig register.
// TESTING
//  1. reset=0 for 3 cycles, then 1, start=0 -> all outputs 0, busy=0, state stays IDLE.
//  2. run_len=5, start pulse at edge t -> lfsr_rst@t+1, lfsr_load@t+2, lfsr_en t+3..t+7,
//     done@t+9, count=5, sig=lfsr_q at t+8.
//  3. run_len=0 -> lfsr_en never high, done@t+4, count=0.
//  4. run_len=10, stop=1 in 2nd RUN cycle -> IDLE next cycle, lfsr_en=0, no done,
//     sig unchanged, count=2.
//  5. reset=0 mid-RUN (between edges) -> lfsr_en/busy drop to 0 without a clock edge,
//     count=0.
//  6. LFSR_SIG_CHECK_EN: lfsr_q=16'hACE1 in DONE, exp_sig=16'hACE1 -> pass=1, fail=0;
//     rerun with exp_sig=16'h0000 -> pass=0, fail=1.

Source files
------------

// File: rtl/lfsr_run_ctrl.sv
// lfsr_run_ctrl: sequencer for the LFSR datapath.
// A run goes clear -> seed load -> run_len enabled steps -> signature capture,
// then a one-cycle done pulse. Either side may abort with stop.
// Optional build macro: LFSR_SIG_CHECK_EN adds an expected-signature compare
// (exp_sig in, pass/fail out). Without it the comparator and its register are absent.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for start; done pulses here for one cycle after a run
// ST_CLR     | one cycle, lfsr_rst high, run counter cleared
// ST_LOAD    | one cycle, lfsr_load high, run length latched
// ST_RUN     | lfsr_en high, one LFSR step per cycle until run length reached
// ST_DONE    | one cycle, LFSR value after the last step captured as signature

module lfsr_run_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] run_len,
  input  logic [WIDTH-1:0] lfsr_q,
`ifdef LFSR_SIG_CHECK_EN
  input  logic [WIDTH-1:0] exp_sig,
  output logic             pass,
  output logic             fail,
`endif
  output logic             lfsr_rst,
  output logic             lfsr_load,
  output logic             lfsr_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] sig
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_LOAD = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] len_q,   len_d;
  logic [WIDTH-1:0] sig_q,   sig_d;
  logic             done_q,  done_d;

  // Strobes are registered from the next state so each output comes straight
  // off a flop and cannot glitch while the encoded state changes.
  logic             rst_q,  load_q, en_q, busy_q;

  // Last enable cycle of the run: the edge that ends it moves to DONE.
  logic             last_step;
  assign last_step = (count_q == (len_q - CNT_W'(1)));

  // Next-state and datapath-register update.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    sig_d   = sig_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // start wins over stop here; stop has no meaning while idle
        if (start) state_d = ST_CLR;
      end

      ST_CLR: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          count_d = '0;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        len_d = run_len;
        if (stop)              state_d = ST_IDLE;
        else if (run_len != '0) state_d = ST_RUN;
        else                   state_d = ST_DONE;
      end

      ST_RUN: begin
        // lfsr_en is high this cycle whether or not we abort, so the step is
        // counted either way; count tracks enables actually issued.
        if (count_q != '1) count_d = count_q + CNT_W'(1);
        if (stop)           state_d = ST_IDLE;
        else if (last_step) state_d = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        if (!stop) begin
          sig_d  = lfsr_q;
          done_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters, signature and registered strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      len_q   <= '0;
      sig_q   <= '0;
      done_q  <= 1'b0;
      rst_q   <= 1'b0;
      load_q  <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      sig_q   <= sig_d;
      done_q  <= done_d;
      rst_q   <= (state_d == ST_CLR);
      load_q  <= (state_d == ST_LOAD);
      en_q    <= (state_d == ST_RUN);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign lfsr_rst  = rst_q;
  assign lfsr_load = load_q;
  assign lfsr_en   = en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign count     = count_q;
  assign sig       = sig_q;

`ifdef LFSR_SIG_CHECK_EN
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;

  // Expected value is taken with the run length; the verdict is cleared at
  // the start of every run so an aborted run reports neither pass nor fail.
  always_comb begin
    exp_d  = exp_q;
    pass_d = pass_q;
    fail_d = fail_q;
    unique case (state_q)
      ST_CLR: begin
        pass_d = 1'b0;
        fail_d = 1'b0;
      end
      ST_LOAD: begin
        exp_d = exp_sig;
      end
      ST_DONE: begin
        if (!stop) begin
          pass_d = (lfsr_q == exp_q);
          fail_d = (lfsr_q != exp_q);
        end
      end
      default: begin
      end
    endcase
  end

  // Signature-check registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q  <= '0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      exp_q  <= exp_d;
      pass_q <= pass_d;
      fail_q <= fail_d;
    end
  end

  assign pass = pass_q;
  assign fail = fail_q;
`endif

endmodule

// File: tb/tb_lfsr_run_ctrl.sv
// Bench for lfsr_run_ctrl. Expected per-cycle output traces are built from the
// documented latency table when a run is launched and compared cycle by cycle.
// A small behavioural LFSR stands in for the datapath.
// Build with LFSR_SIG_CHECK_EN defined to also exercise pass/fail.

module tb_lfsr_run_ctrl;

  localparam int WIDTH = 16;
  localparam int CNT_W = 16;
  localparam logic [WIDTH-1:0] SEED = 16'hACE1;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] run_len;
  logic [WIDTH-1:0] lfsr_q;
  logic             lfsr_rst, lfsr_load, lfsr_en, busy, done;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] sig;
  logic [WIDTH-1:0] exp_sig;
  logic             pass, fail;

  always #5 clk = ~clk;

  lfsr_run_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .run_len   (run_len),
    .lfsr_q    (lfsr_q),
`ifdef LFSR_SIG_CHECK_EN
    .exp_sig   (exp_sig),
    .pass      (pass),
    .fail      (fail),
`endif
    .lfsr_rst  (lfsr_rst),
    .lfsr_load (lfsr_load),
    .lfsr_en   (lfsr_en),
    .busy      (busy),
    .done      (done),
    .count     (count),
    .sig       (sig)
  );

`ifndef LFSR_SIG_CHECK_EN
  assign pass = 1'b0;
  assign fail = 1'b0;
`endif

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [WIDTH-1:0] sig_after(input int n);
    logic [WIDTH-1:0] x;
    x = SEED;
    for (int i = 0; i < n; i++) x = lfsr_step(x);
    return x;
  endfunction

  // behavioural LFSR datapath driven by the controller strobes
  always @(posedge clk) begin
    if (lfsr_rst)       lfsr_q <= '0;
    else if (lfsr_load) lfsr_q <= SEED;
    else if (lfsr_en)   lfsr_q <= lfsr_step(lfsr_q);
  end

  // strb = {lfsr_rst, lfsr_load, lfsr_en, busy, done}
  typedef struct packed {
    logic [4:0]       strb;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sig;
    logic             pfc;
    logic             pass;
    logic             fail;
  } exp_t;

  typedef struct packed {
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] len;
    logic [WIDTH-1:0] esig;
  } stim_t;

  exp_t  exp_q[$];
  stim_t stim_q[$];

  int n_chk = 0;
  int n_err = 0;

  logic [CNT_W-1:0] m_count = '0;
  logic [WIDTH-1:0] m_sig   = '0;
  logic             m_pass  = 1'b0;
  logic             m_fail  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic exp_t mk(input logic [4:0] strb, input logic [CNT_W-1:0] c,
                              input logic [WIDTH-1:0] s, input logic pfc);
    exp_t e;
    e.strb = strb; e.cnt = c; e.sig = s; e.pfc = pfc;
    e.pass = m_pass; e.fail = m_fail;
    return e;
  endfunction

  function automatic stim_t ms(input logic st, input logic sp, input int n,
                               input logic [WIDTH-1:0] es);
    stim_t s;
    s.start = st; s.stop = sp; s.len = CNT_W'(n); s.esig = es;
    return s;
  endfunction

  // Build the expected trace for one run of length n launched from an idle
  // period. stop_p: period index (1 = CLR) in which stop is raised, 0 = none.
  // hold: start stays high throughout, so the done cycle starts the next run.
  // skip_p0: the launching idle period was already queued by a previous hold run.
  // ss0: raise stop together with start in the launching idle period.
  task automatic gen_run(input int n, input int stop_p, input bit hold,
                         input bit skip_p0, input bit ss0, input logic [WIDTH-1:0] es);
    logic [WIDTH-1:0] new_sig;
    logic [CNT_W-1:0] c;
    logic [4:0]       sb;
    int               last;
    new_sig = sig_after(n);
    if (!skip_p0) begin
      exp_q.push_back(mk(5'b00000, m_count, m_sig, 1'b0));
      stim_q.push_back(ms(1'b1, ss0, n, es));
    end
    last = (stop_p != 0) ? stop_p : n + 3;
    for (int p = 1; p <= last; p++) begin
      if (p == 1)          begin sb = 5'b10010; c = m_count;        end
      else if (p == 2)     begin sb = 5'b01010; c = '0;             end
      else if (p <= n + 2) begin sb = 5'b00110; c = CNT_W'(p - 3);  end
      else                 begin sb = 5'b00010; c = CNT_W'(n);      end
      exp_q.push_back(mk(sb, c, m_sig, 1'b0));
      stim_q.push_back(ms(hold, (p == stop_p), n, es));
    end
    if (stop_p != 0) begin
      if (stop_p == 1)          m_count = m_count;
      else if (stop_p == 2)     m_count = '0;
      else if (stop_p <= n + 2) m_count = CNT_W'(stop_p - 2);
      else                      m_count = CNT_W'(n);
      m_pass = 1'b0;
      m_fail = 1'b0;
      exp_q.push_back(mk(5'b00000, m_count, m_sig, 1'b1));
      stim_q.push_back(ms(1'b0, 1'b0, n, es));
    end else begin
      m_count = CNT_W'(n);
      m_sig   = new_sig;
      m_pass  = (new_sig == es);
      m_fail  = (new_sig != es);
      exp_q.push_back(mk(5'b00001, m_count, m_sig, 1'b1));
      stim_q.push_back(ms(hold, 1'b0, n, es));
      if (!hold) begin
        exp_q.push_back(mk(5'b00000, m_count, m_sig, 1'b1));
        stim_q.push_back(ms(1'b0, 1'b0, n, es));
      end
    end
  endtask

  // One queue entry per clock period: compare mid-period, then drive that
  // period's inputs ahead of its closing edge.
  task automatic run_q();
    exp_t  e;
    stim_t s;
    while (stim_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      s = stim_q.pop_front();
      chk("strobes", 32'({lfsr_rst, lfsr_load, lfsr_en, busy, done}), 32'(e.strb));
      chk("count", 32'(count), 32'(e.cnt));
      chk("sig", 32'(sig), 32'(e.sig));
`ifdef LFSR_SIG_CHECK_EN
      if (e.pfc) chk("pass_fail", 32'({pass, fail}), 32'({e.pass, e.fail}));
`endif
      start   = s.start;
      stop    = s.stop;
      run_len = s.len;
      exp_sig = s.esig;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; run_len = '0; exp_sig = '0;
    repeat (3) @(negedge clk);
    chk("rst_strobes", 32'({lfsr_rst, lfsr_load, lfsr_en, busy, done}), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_sig", 32'(sig), 32'd0);
    chk("rst_pass_fail", 32'({pass, fail}), 32'd0);
    reset = 1'b1;

    // idle with start low; stop alone in idle does nothing
    exp_q.push_back(mk(5'b00000, '0, '0, 1'b1)); stim_q.push_back(ms(1'b0, 1'b0, 0, '0));
    exp_q.push_back(mk(5'b00000, '0, '0, 1'b1)); stim_q.push_back(ms(1'b0, 1'b1, 0, '0));
    exp_q.push_back(mk(5'b00000, '0, '0, 1'b1)); stim_q.push_back(ms(1'b0, 1'b0, 0, '0));
    run_q();

    gen_run(5, 0, 1'b0, 1'b0, 1'b0, sig_after(5));     run_q();  // basic run
    gen_run(0, 0, 1'b0, 1'b0, 1'b0, 16'h1234);         run_q();  // zero length
    gen_run(10, 4, 1'b0, 1'b0, 1'b0, 16'h0000);        run_q();  // abort in 2nd RUN cycle
    gen_run(3, 6, 1'b0, 1'b0, 1'b0, 16'h0000);         run_q();  // abort in DONE
    gen_run(4, 0, 1'b0, 1'b0, 1'b1, 16'h0000);         run_q();  // start+stop in idle
    gen_run(2, 0, 1'b1, 1'b0, 1'b0, sig_after(2));               // start held high
    gen_run(2, 0, 1'b0, 1'b1, 1'b0, sig_after(2));     run_q();
    gen_run(0, 0, 1'b0, 1'b0, 1'b0, 16'hACE1);         run_q();  // signature match
    gen_run(0, 0, 1'b0, 1'b0, 1'b0, 16'h0000);         run_q();  // signature mismatch
    gen_run(7, 2, 1'b0, 1'b0, 1'b0, 16'h0000);         run_q();  // abort in LOAD

    // asynchronous reset in the middle of a run
    @(negedge clk); start = 1'b1; run_len = 16'd10;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_en", 32'(lfsr_en), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_strobes", 32'({lfsr_rst, lfsr_load, lfsr_en, busy, done}), 32'd0);
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_sig", 32'(sig), 32'd0);
    @(negedge clk); reset = 1'b1;
    m_count = '0; m_sig = '0; m_pass = 1'b0; m_fail = 1'b0;

    gen_run(1, 0, 1'b0, 1'b0, 1'b0, sig_after(1));     run_q();  // recovery

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
